pr_port_arbiter: RTL
====================

Name: pr_port_arbiter

Overview:
- Shares the single PixelRender Avalon-MM slave port (32-bit data, 10-bit word address, 960 words) among NREQ requesters: clear sequencer, CPU bridge, path painter.
- Runs one transaction at a time. Grants round-robin, captures the granted request into registers, and holds it on the slave port until WAIT_REQUEST_PR drops.
- For reads, returns the data after the slave's fixed read latency.
- Sits between the top-level control FSM/Dijkstra core and the PixelRender slave.

Parameters:
- NREQ, 3, number of requesters; requester 0 has first grant after reset.
- AW, 10, slave word-address width.
- DW, 32, data width; byte-enable width is DW/8.
- READ_LATENCY, 1, cycles from read acceptance to valid READDATA_PR (1..4).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- req_write  in  NREQ  per-requester write request; held until ack.
- req_read  in  NREQ  per-requester read request; held until ack.
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_be  in  NREQ*DW/8  packed byte enables.
- ack  out  NREQ  one-cycle pulse: requester's transaction accepted by slave.
- rdata_valid  out  NREQ  one-cycle pulse to read owner: rdata valid.
- rdata  out  DW  read data, shared; meaningful only with rdata_valid.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NREQ)  index of current/last granted requester.
- CS_PR  out  1  slave chip select.
- WRITE_PR  out  1  slave write strobe.
- READ_PR  out  1  slave read strobe.
- ADDRESS_PR  out  AW  slave address.
- BYTE_EN_PR  out  DW/8  slave byte enables.
- WRITEDATA_PR  out  DW  slave write data.
- READDATA_PR  in  DW  slave read data.
- WAIT_REQUEST_PR  in  1  slave stall; transfer accepted on a cycle with strobe high and WAIT_REQUEST_PR low.

Behaviour:
- Reset, applied next edge, also mid-transaction:
  - All outputs 0: strobes, CS, address, data, BYTE_EN, ack, rdata_valid, rdata, busy, grant_id.
  - State=IDLE; last-grant pointer=NREQ-1.
  - An in-flight slave transfer is abandoned; no ack is issued.
- Request definition: requester i is pending when req_write[i] | req_read[i].
  - If both are set, it is treated as a write; the read is dropped and the requester must re-issue it.
- IDLE:
  - If any request is pending, pick the first pending index scanning (last+1) mod NREQ upward with wrap.
  - Register its addr/wdata/be/type, set grant_id and last, go to ISSUE.
  - No pending request: stay in IDLE with outputs 0.
- ISSUE:
  - CS_PR=1; WRITE_PR or READ_PR=1 per captured type; ADDRESS/BYTE_EN/WRITEDATA from the capture registers.
  - Captured values are stable regardless of later requester input changes.
  - While WAIT_REQUEST_PR=1, hold everything.
  - On the cycle with WAIT_REQUEST_PR=0, assert ack[grant_id] combinationally in that same cycle.
  - Next state: write → IDLE; read → RDWAIT with counter=READ_LATENCY.
- RDWAIT:
  - Strobes and CS are 0; the counter decrements each cycle.
  - READDATA_PR is sampled when it is valid, READ_LATENCY cycles after acceptance.
  - Next cycle: rdata holds the sampled value and rdata_valid[grant_id]=1 for exactly one cycle; then IDLE.
- Minimum cost:
  - Write: 1 cycle IDLE + 1 cycle ISSUE when there are no stalls.
  - Read: rdata_valid arrives READ_LATENCY+1 cycles after ack.
- Requester drops its request before ack: the captured transaction still completes and is acked; ack is then ignored by the requester.
- New request on the cycle ack is issued is arbitrated in IDLE on the following cycle; there are no back-to-back grants without an IDLE cycle.
- Fairness: with all NREQ requesters continuously pending, grants cycle 0,1,2,0,...; no requester waits more than NREQ-1 transactions.
- ack and rdata_valid are one-hot or zero; never asserted for a non-granted index.

Test Plan:
- Reset, then requester 1 writes addr 10'd5, data 32'hDEADBEEF, be 4'hF, WAIT_REQUEST_PR=0 → one cycle later CS_PR=WRITE_PR=1, ADDRESS_PR=5, WRITEDATA_PR=32'hDEADBEEF, ack=3'b010 that cycle; back to IDLE.
- All three requesters write continuously → grant_id sequence 0,1,2,0,1,2; each ack is one-hot and matches grant_id.
- Requester 2 reads addr 10'd959 with WAIT_REQUEST_PR held high 3 cycles; slave returns 32'h12345678 at latency 1 → strobes held 4 cycles with stable address, ack[2] on the 4th; rdata_valid=3'b100 with rdata=32'h12345678 two cycles after ack.
- Requester 0 asserts write and read together to addr 10'd7 → only WRITE_PR strobes, one ack[0], no rdata_valid.
- Requester 1 changes req_addr from 10'd3 to 10'd9 and drops the request during a stall → slave sees address 3 throughout; ack[1] still pulses once.
- Reset asserted mid-ISSUE with WAIT_REQUEST_PR=1 → next cycle all outputs 0, no ack; then a request from requester 2 alone gets grant_id=2.

Source files
------------

// File: rtl/pr_port_arbiter.sv
// Round-robin arbiter sharing the single PixelRender Avalon-MM slave port among NREQ requesters.
// One transaction at a time: capture in IDLE, hold on the slave in ISSUE, wait out read latency in RDWAIT.
module pr_port_arbiter #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                                       Clk,
    input  logic                                       Reset,
    input  logic [NREQ-1:0]                            req_write,
    input  logic [NREQ-1:0]                            req_read,
    input  logic [NREQ*AW-1:0]                         req_addr,
    input  logic [NREQ*DW-1:0]                         req_wdata,
    input  logic [NREQ*(DW/8)-1:0]                     req_be,
    output logic [NREQ-1:0]                            ack,
    output logic [NREQ-1:0]                            rdata_valid,
    output logic [DW-1:0]                              rdata,
    output logic                                       busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                                       CS_PR,
    output logic                                       WRITE_PR,
    output logic                                       READ_PR,
    output logic [AW-1:0]                              ADDRESS_PR,
    output logic [DW/8-1:0]                            BYTE_EN_PR,
    output logic [DW-1:0]                              WRITEDATA_PR,
    input  logic [DW-1:0]                              READDATA_PR,
    input  logic                                       WAIT_REQUEST_PR
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t          state;
    logic [GW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] pending;
    logic            pick_valid;
    logic [GW-1:0]   pick;
    logic            accept;
    int unsigned     scan_idx;

    assign pending = req_write | req_read;
    assign accept  = (state == ISSUE) && !WAIT_REQUEST_PR;

    // Round-robin scan starting just after the last grant, wrapping around
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        scan_idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = (32'(last) + k) % NREQ;
            if (!pick_valid && pending[GW'(scan_idx)]) begin
                pick_valid = 1'b1;
                pick       = GW'(scan_idx);
            end
        end
    end

    // Acceptance is acknowledged in the same cycle the slave drops its stall
    always_comb begin
        ack = '0;
        if (accept && !Reset) begin
            ack[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            last         <= GW'(NREQ - 1);
            cnt          <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            CS_PR        <= 1'b0;
            WRITE_PR     <= 1'b0;
            READ_PR      <= 1'b0;
            ADDRESS_PR   <= '0;
            BYTE_EN_PR   <= '0;
            WRITEDATA_PR <= '0;
            rdata_valid  <= '0;
            rdata        <= '0;
        end else begin
            rdata_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        grant_id     <= pick;
                        last         <= pick;
                        CS_PR        <= 1'b1;
                        // A simultaneous read request is dropped in favour of the write
                        WRITE_PR     <= req_write[pick];
                        READ_PR      <= !req_write[pick];
                        ADDRESS_PR   <= req_addr[32'(pick)*AW +: AW];
                        BYTE_EN_PR   <= req_be[32'(pick)*BW +: BW];
                        WRITEDATA_PR <= req_wdata[32'(pick)*DW +: DW];
                    end
                end
                ISSUE: begin
                    if (!WAIT_REQUEST_PR) begin
                        CS_PR        <= 1'b0;
                        WRITE_PR     <= 1'b0;
                        READ_PR      <= 1'b0;
                        ADDRESS_PR   <= '0;
                        BYTE_EN_PR   <= '0;
                        WRITEDATA_PR <= '0;
                        if (WRITE_PR) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RDWAIT;
                            cnt   <= CW'(READ_LATENCY);
                        end
                    end
                end
                RDWAIT: begin
                    cnt <= cnt - CW'(1);
                    // Slave data is valid in the last counted cycle
                    if (cnt == CW'(1)) begin
                        rdata                 <= READDATA_PR;
                        rdata_valid[grant_id] <= 1'b1;
                        state                 <= IDLE;
                        busy                  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
